sipo_frame_ctrl: RTL
====================

SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Parameters
REQ-001 The block SHALL take parameter WIDTH, default 10, the deserialized word width.
REQ-002 The block SHALL take parameter SYNC_WORD, default 10'b0011111010, the alignment pattern.
REQ-003 The block SHALL take parameter MAX_GAP, default 16, the data words allowed between syncs before loss of lock.

Interface
REQ-004 The block SHALL have clk_1250Mhrz, input, 1, the single system clock; all logic on its rising edge.
REQ-005 The block SHALL have rst, input, 1; reset is asynchronous and active-low.
REQ-006 The block SHALL have en, input, 1, the serial bit qualifier; din is sampled only when en=1.
REQ-007 The block SHALL have din, input, 1, the serial data bit.
REQ-008 The block SHALL have dout, output, WIDTH, the head-of-buffer parallel word.
REQ-009 The block SHALL have dout_valid, output, 1, asserted when the buffer is non-empty.
REQ-010 The block SHALL have dout_ready, input, 1, the consumer accept; a pop occurs when dout_valid=1 and dout_ready=1.
REQ-011 The block SHALL have locked, output, 1, high only in state LOCKED.
REQ-012 The block SHALL have overflow, output, 1, a sticky word-drop flag.
REQ-013 The block SHALL have ovf_clr, input, 1, a synchronous clear of overflow.

Function
REQ-014 On each en=1 edge the shift register SHALL update as sr <= {din, sr[WIDTH-1:1]}, so the first-received bit lands in bit 0; with en=0, sr, bit counter and FSM SHALL hold.
REQ-015 FSM states SHALL be HUNT, VERIFY and LOCKED.
REQ-016 In HUNT, on each en=1 edge the post-shift value SHALL be compared to SYNC_WORD; a match SHALL go to VERIFY with bitcnt=0.
REQ-017 bitcnt SHALL be 4 bits, count 0..WIDTH-1 on en=1 in VERIFY/LOCKED, and wrap 9->0; the edge with bitcnt=9 and en=1 SHALL be the word boundary.
REQ-018 In VERIFY, at the word boundary, a post-shift match SHALL go to LOCKED and a mismatch SHALL go to HUNT; no word SHALL be pushed in VERIFY or HUNT.
REQ-019 In LOCKED, at the word boundary, a SYNC_WORD match SHALL be discarded and clear gapcnt; any other word SHALL be pushed and increment gapcnt.
REQ-020 A push that makes gapcnt reach MAX_GAP SHALL still be pushed, and the FSM SHALL then go to HUNT.
REQ-021 The output buffer SHALL be a 2-entry FIFO; a pushed word SHALL appear on dout with dout_valid=1 one cycle after the boundary edge when the buffer was empty.
REQ-022 dout and dout_valid SHALL be registered and stable while dout_valid=1 and dout_ready=0.
REQ-023 A push into a full buffer without a same-cycle pop SHALL drop the new word and set overflow.
REQ-024 A simultaneous push and pop on a full buffer SHALL accept both; overflow SHALL remain unchanged.
REQ-025 A simultaneous ovf_clr and overflow-set SHALL leave overflow set (set wins).
REQ-026 Leaving LOCKED SHALL NOT flush the buffer; buffered words SHALL remain poppable.

Reset
REQ-027 On rst=0, asynchronously, sr, bitcnt, gapcnt, the buffer pointers and count, dout, dout_valid, locked and overflow SHALL be 0, and the FSM SHALL be in HUNT.
REQ-028 Reset asserted mid-word SHALL discard the partial word and all buffered words; after release, alignment SHALL restart from HUNT.

Structure
REQ-029 Package sipo_ctrl_pkg SHALL hold the FSM state enum, WIDTH default, SYNC_WORD default and MAX_GAP default.
REQ-030 The 2-entry FIFO SHALL be a separate sub-module, sipo_word_fifo, parameterized by WIDTH; shift register, counters and FSM SHALL stay in sipo_frame_ctrl.

Verification
REQ-031 Feed SYNC_WORD twice, then 10'h155 with en=1 every cycle -> locked=1 after the second sync; dout=10'h155 with dout_valid=1 one cycle after its 10th bit.
REQ-032 Feed SYNC_WORD followed by a non-sync word -> VERIFY returns to HUNT, locked stays 0, and no dout_valid.
REQ-033 Hold dout_ready=0 while locked and stream 3 data words -> first 2 are held in order, the 3rd is dropped, and overflow=1; ovf_clr=1 -> overflow=0.
REQ-034 Toggle en 1/0 every cycle during a word -> dout matches the en=1-sampled bits only, at half the rate.
REQ-035 Stream 16 data words with no sync -> the 16th is delivered, then locked=0 and the FSM is in HUNT.
REQ-036 Assert rst=0 at bitcnt=5 with 1 word buffered -> all outputs 0 immediately; after release, no word is output until resync.

Source files
------------

// File: rtl/sipo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sipo_ctrl_pkg
// Shared definitions for the serial-to-parallel framing controller:
//   - frame_state_t     : alignment FSM states (HUNT / VERIFY / LOCKED)
//   - WIDTH_DEFAULT     : default deserialized word width
//   - SYNC_WORD_DEFAULT : default alignment pattern
//   - MAX_GAP_DEFAULT   : default number of data words allowed between syncs
//   - cnt_bits()        : width of a counter able to hold 0..n-1
// -----------------------------------------------------------------------------
package sipo_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } frame_state_t;

  localparam int         WIDTH_DEFAULT     = 10;
  localparam logic [9:0] SYNC_WORD_DEFAULT = 10'b0011111010;
  localparam int         MAX_GAP_DEFAULT   = 16;

  // Minimum counter width for values 0..n-1 (never narrower than one bit).
  function automatic int cnt_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sipo_word_fifo.sv
// -----------------------------------------------------------------------------
// sipo_word_fifo
// Two-entry word buffer with a registered head-of-queue output.
//   clk_1250Mhrz : system clock, rising edge
//   rst          : asynchronous active-low reset
//   push         : write push_data this cycle
//   push_data    : word to store
//   dout_ready   : consumer accept; a pop happens when dout_valid & dout_ready
//   ovf_clr      : synchronous clear of overflow
//   dout         : head word (registered)
//   dout_valid   : buffer non-empty (registered)
//   overflow     : sticky flag, set when a push finds the buffer full
// -----------------------------------------------------------------------------
module sipo_word_fifo
  import sipo_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk_1250Mhrz,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             dout_ready,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             overflow
);

  localparam int DEPTH = 2;

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [DEPTH-1:0] wr_en;

  logic             wr_ptr_reg, wr_ptr_next;
  logic             rd_ptr_reg, rd_ptr_next;
  logic [1:0]       count_reg, count_next;
  logic [WIDTH-1:0] dout_reg, dout_next;
  logic             dout_valid_reg, dout_valid_next;
  logic             overflow_reg, overflow_next;

  logic             pop;
  logic             full;
  logic             push_ok;
  logic             drop;

  assign pop     = dout_valid_reg & dout_ready;
  assign full    = (count_reg == 2'd2);
  // A full buffer can still take a word when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push_ok & (wr_ptr_reg == 1'(gi));
    end
  endgenerate

  // Storage carries no reset: contents are only observed through dout_reg,
  // which is qualified by the reset-cleared count.
  always_ff @(posedge clk_1250Mhrz) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) begin
        mem[i] <= push_data;
      end
    end
  end

  always_comb begin
    wr_ptr_next     = wr_ptr_reg ^ push_ok;
    rd_ptr_next     = rd_ptr_reg ^ pop;
    count_next      = count_reg;
    if (push_ok && !pop) begin
      count_next = count_reg + 2'd1;
    end else if (!push_ok && pop) begin
      count_next = count_reg - 2'd1;
    end
    dout_valid_next = (count_next != 2'd0);

    // The output register tracks the slot that will be the head after this
    // edge; when that slot is being written now, bypass the array.
    dout_next = dout_reg;
    if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
      dout_next = push_data;
    end else if (count_next != 2'd0) begin
      dout_next = mem[rd_ptr_next];
    end

    // A set in the same cycle as a clear wins.
    overflow_next = (overflow_reg & ~ovf_clr) | drop;
  end

  always_ff @(posedge clk_1250Mhrz or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg     <= 1'b0;
      rd_ptr_reg     <= 1'b0;
      count_reg      <= 2'd0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
      overflow_reg   <= overflow_next;
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign overflow   = overflow_reg;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// -----------------------------------------------------------------------------
// sipo_frame_ctrl
// Serial-to-parallel deserializer with sync-word alignment and a 2-word
// output buffer.
//   clk_1250Mhrz : system clock, rising edge
//   rst          : asynchronous active-low reset
//   en           : serial bit qualifier; din sampled only when en=1
//   din          : serial data bit, first-received bit ends up in bit 0
//   dout         : head-of-buffer parallel word
//   dout_valid   : buffer non-empty
//   dout_ready   : consumer accept
//   locked       : word alignment established (FSM in LOCKED)
//   overflow     : sticky flag, a data word was dropped on a full buffer
//   ovf_clr      : synchronous clear of overflow
// Alignment: HUNT slides bit by bit until the shift register holds SYNC_WORD,
// VERIFY requires the next whole word to be SYNC_WORD too, LOCKED delivers
// every non-sync word and falls back to HUNT after MAX_GAP data words without
// an intervening sync.
// -----------------------------------------------------------------------------
module sipo_frame_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int               WIDTH     = WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] SYNC_WORD = SYNC_WORD_DEFAULT,
  parameter int               MAX_GAP   = MAX_GAP_DEFAULT
) (
  input  logic             clk_1250Mhrz,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             locked,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int CNT_W = cnt_bits(WIDTH);
  localparam int GAP_W = cnt_bits(MAX_GAP + 1);

  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(MAX_GAP);

  frame_state_t     state_reg, state_next;
  logic [WIDTH-1:0] sr_reg, sr_next;
  logic [CNT_W-1:0] bitcnt_reg, bitcnt_next;
  logic [GAP_W-1:0] gapcnt_reg, gapcnt_next;
  logic             push_reg, push_next;
  logic [WIDTH-1:0] word_reg, word_next;

  logic [WIDTH-1:0] sr_shift;
  logic             is_sync;
  logic             boundary;
  logic [CNT_W-1:0] bitcnt_inc;
  logic [GAP_W-1:0] gapcnt_inc;

  // All alignment decisions look at the value the register will hold after
  // this edge, so a word is judged on the same edge its last bit arrives.
  assign sr_shift   = {din, sr_reg[WIDTH-1:1]};
  assign is_sync    = (sr_shift == SYNC_WORD);
  assign boundary   = (bitcnt_reg == LAST_BIT);
  assign bitcnt_inc = boundary ? '0 : (bitcnt_reg + 1'b1);
  assign gapcnt_inc = gapcnt_reg + 1'b1;

  always_comb begin
    state_next  = state_reg;
    sr_next     = sr_reg;
    bitcnt_next = bitcnt_reg;
    gapcnt_next = gapcnt_reg;
    push_next   = 1'b0;
    word_next   = word_reg;

    if (en) begin
      sr_next = sr_shift;
      unique case (state_reg)
        ST_HUNT: begin
          if (is_sync) begin
            state_next  = ST_VERIFY;
            bitcnt_next = '0;
          end
        end

        ST_VERIFY: begin
          bitcnt_next = bitcnt_inc;
          if (boundary) begin
            gapcnt_next = '0;
            state_next  = is_sync ? ST_LOCKED : ST_HUNT;
          end
        end

        ST_LOCKED: begin
          bitcnt_next = bitcnt_inc;
          if (boundary) begin
            if (is_sync) begin
              // Sync words only refresh the gap watchdog.
              gapcnt_next = '0;
            end else begin
              push_next   = 1'b1;
              word_next   = sr_shift;
              gapcnt_next = gapcnt_inc;
              // The word that exhausts the gap budget is still delivered.
              if (gapcnt_inc == GAP_LIMIT) begin
                state_next  = ST_HUNT;
                gapcnt_next = '0;
              end
            end
          end
        end

        default: begin
          state_next = ST_HUNT;
        end
      endcase
    end
  end

  // push/word are registered so the buffer sees the word one edge after its
  // boundary, making it visible on dout one cycle after that boundary edge.
  always_ff @(posedge clk_1250Mhrz or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_HUNT;
      sr_reg     <= '0;
      bitcnt_reg <= '0;
      gapcnt_reg <= '0;
      push_reg   <= 1'b0;
      word_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      sr_reg     <= sr_next;
      bitcnt_reg <= bitcnt_next;
      gapcnt_reg <= gapcnt_next;
      push_reg   <= push_next;
      word_reg   <= word_next;
    end
  end

  assign locked = (state_reg == ST_LOCKED);

  sipo_word_fifo #(
    .WIDTH (WIDTH)
  ) u_word_fifo (
    .clk_1250Mhrz (clk_1250Mhrz),
    .rst          (rst),
    .push         (push_reg),
    .push_data    (word_reg),
    .dout_ready   (dout_ready),
    .ovf_clr      (ovf_clr),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .overflow     (overflow)
  );

endmodule
